// File: rtl/axi_read_slave.sv
// AXI3 read-channel slave: accepts one read burst at a time and returns each
// beat from a synchronous single-port word memory (one-cycle read latency).
module axi_read_slave #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]   id_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        len_reg;
  logic [2:0]        size_reg;
  logic [1:0]        burst_reg;
  logic              err_reg;
  logic [3:0]        beat_reg;
  logic              fresh_reg;
  logic [DATA_W-1:0] rdata_reg;

  // Request-time error classification, evaluated on the live AR inputs.
  logic [ADDR_W-1:0] ar_size_bytes;
  logic [ADDR_W-1:0] ar_offset;
  logic [ADDR_W-1:0] ar_word;
  logic              ar_below_base;
  logic              ar_wrap_len_ok;
  logic              ar_misaligned;
  logic              ar_err;

  assign ar_size_bytes                = ADDR_W'(1) << ARSIZE;
  assign {ar_below_base, ar_offset}   = {1'b0, ARADDR} - {1'b0, BASE_ADDR};
  assign ar_word                      = ar_offset >> 2;
  assign ar_wrap_len_ok               = ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15};
  assign ar_misaligned                = (ARADDR & (ar_size_bytes - ADDR_W'(1))) != '0;

  assign ar_err = (ARBURST == BURST_RSVD)
               || (ARSIZE > 3'd2)
               || ((ARBURST == BURST_WRAP) && (!ar_wrap_len_ok || ar_misaligned))
               || ar_below_base
               || (|ar_word[ADDR_W-1:MEM_AW]);

  // Current-beat address decode; INCR bursts can run off the end of memory.
  logic [ADDR_W-1:0] size_bytes;
  logic [ADDR_W-1:0] wrap_len;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic              below_base;
  logic              beat_err;

  assign size_bytes              = ADDR_W'(1) << size_reg;
  assign wrap_len                = ADDR_W'({1'b0, len_reg} + 5'd1) << size_reg;
  assign {below_base, offset}    = {1'b0, addr_reg} - {1'b0, BASE_ADDR};
  assign word_idx                = offset >> 2;
  assign beat_err                = err_reg || below_base || (|word_idx[ADDR_W-1:MEM_AW]);

  // Next beat address: INCR realigns to the beat size so an unaligned start
  // only affects the first beat; WRAP stays inside the L-byte aligned window.
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_addr;
  logic [ADDR_W-1:0] addr_next;

  assign incr_addr = (addr_reg & ~(size_bytes - ADDR_W'(1))) + size_bytes;
  assign wrap_addr = (addr_reg & ~(wrap_len - ADDR_W'(1)))
                   | ((addr_reg + size_bytes) & (wrap_len - ADDR_W'(1)));

  always_comb begin
    addr_next = incr_addr;
    case (burst_reg)
      BURST_FIXED: addr_next = addr_reg;
      BURST_WRAP:  addr_next = wrap_addr;
      default:     addr_next = incr_addr;
    endcase
  end

  logic last_beat;
  logic ar_fire;
  logic r_advance;

  assign last_beat = (beat_reg == len_reg);
  assign ar_fire   = (state_reg == IDLE) && ARVALID;
  assign r_advance = (state_reg == RESP) && RREADY && !last_beat;

  always_comb begin
    state_next = state_reg;
    ARREADY    = 1'b0;
    RVALID     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    case (state_reg)
      IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) state_next = FETCH;
      end
      FETCH: begin
        mem_rd     = !beat_err;
        mem_addr   = word_idx[MEM_AW-1:0];
        state_next = RESP;
      end
      RESP: begin
        RVALID = 1'b1;
        if (RREADY) state_next = last_beat ? IDLE : FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      err_reg   <= 1'b0;
      beat_reg  <= '0;
      fresh_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      fresh_reg <= (state_reg == FETCH);
      if (ar_fire) begin
        id_reg    <= ARID;
        addr_reg  <= ARADDR;
        len_reg   <= ARLEN;
        size_reg  <= ARSIZE;
        burst_reg <= ARBURST;
        err_reg   <= ar_err;
        beat_reg  <= '0;
      end
      // Memory output is only guaranteed on the first RESP cycle; keep a copy for stalls.
      if ((state_reg == RESP) && fresh_reg) rdata_reg <= mem_rdata;
      if (r_advance) begin
        addr_reg <= addr_next;
        beat_reg <= beat_reg + 4'd1;
      end
    end
  end

  assign RID   = id_reg;
  assign RLAST = RVALID && last_beat;
  assign RRESP = (RVALID && beat_err) ? RESP_SLVERR : RESP_OKAY;
  assign RDATA = (!RVALID || beat_err) ? '0 : (fresh_reg ? mem_rdata : rdata_reg);

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: directed scenarios plus random bursts checked each
// cycle against a burst-level reference model built from the addressing rules.
module tb_axi_read_slave;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] TB_BASE   = 32'h0000_0100;
  localparam logic [31:0] VAL_A     = 32'hA0A0_0004;
  localparam logic [31:0] VAL_B     = 32'hB0B0_0005;
  localparam logic [31:0] VAL_C     = 32'hC0C0_0006;
  localparam logic [31:0] VAL_D     = 32'hD0D0_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;

  axi_read_slave #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_AW(10), .BASE_ADDR(TB_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_beats[$];
  int          exp_words[$];
  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [3:0]  got_id[$];
  int          got_words[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int rv_cyc = 0;
  bit rv_seen = 1'b0;
  bit busy = 1'b0;
  int gap = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_beats.delete();
    exp_words.delete();
    busy = 1'b0;
    gap  = 0;
  endtask

  // Expected beats of one burst, derived directly from the address/error rules.
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
    longint a, sz, wl, base, wrd;
    bit     err, berr;
    beat_t  b;
    a   = longint'(addr);
    sz  = longint'(1) << size;
    wl  = (longint'(len) + 1) * sz;
    err = (burst == 2'b11) || (size > 3'd2)
       || (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
       || (burst == 2'b10 && (a % sz) != 0)
       || (a < longint'(TB_BASE))
       || ((a - longint'(TB_BASE)) / 4 >= MEM_WORDS);
    for (int i = 0; i <= int'(len); i++) begin
      berr = err || (a < longint'(TB_BASE)) || ((a - longint'(TB_BASE)) / 4 >= MEM_WORDS);
      wrd  = berr ? 0 : (a - longint'(TB_BASE)) / 4;
      b.id   = id;
      b.data = berr ? 32'h0 : mem[int'(wrd)];
      b.resp = berr ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_beats.push_back(b);
      if (!berr) exp_words.push_back(int'(wrd));
      case (burst)
        2'b00: a = a;
        2'b10: begin
          base = (a / wl) * wl;
          a    = base + ((a + sz) % wl);
        end
        default: a = ((a / sz) * sz + sz) % (longint'(1) << 32);
      endcase
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      cyc++;
      chk("arready", ARREADY, !busy);
      chk("rvalid", RVALID, busy && gap == 0);
      if (mem_rd) begin
        got_words.push_back(int'(mem_addr));
        if (exp_words.size() == 0) chk("mem_rd_unexpected", mem_rd, 0);
        else chk("mem_addr", mem_addr, exp_words.pop_front());
      end
      if (gap > 0) gap--;
      if (RVALID) begin
        if (!rv_seen) begin
          rv_seen = 1'b1;
          rv_cyc  = cyc;
        end
        if (exp_beats.size() == 0) begin
          chk("rvalid_unexpected", RVALID, 0);
        end else begin
          e = exp_beats[0];
          chk("rid", RID, e.id);
          chk("rdata", RDATA, e.data);
          chk("rresp", RRESP, e.resp);
          chk("rlast", RLAST, e.last);
          if (RREADY) begin
            void'(exp_beats.pop_front());
            got_data.push_back(RDATA);
            got_resp.push_back(RRESP);
            got_last.push_back(RLAST);
            got_id.push_back(RID);
            if (e.last) busy = 1'b0;
            else gap = 1;
          end
        end
      end
      if (ARVALID && ARREADY) begin
        busy    = 1'b1;
        gap     = 1;
        hs_cyc  = cyc;
        rv_seen = 1'b0;
      end
    end
  end

  // rmode: 0 RREADY always high, 1 random RREADY, 2 stall beat 2 for three
  // cycles, 3 assert reset while beat 2 is presented.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int rmode);
    int n, idx, stall_left;
    got_data.delete(); got_resp.delete(); got_last.delete();
    got_id.delete(); got_words.delete();
    n = 0;
    while (!ARREADY && n < 50) begin
      tick();
      n++;
    end
    chk("ar_ready_wait", ARREADY, 1);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    model_push(id, addr, len, size, burst);
    tick();
    ARVALID = 1'b0;
    ARADDR  = $urandom();
    ARID    = 4'($urandom());
    stall_left = 3;
    n = 0;
    while ((exp_beats.size() != 0 || busy) && n < 400) begin
      idx = int'(len) + 1 - exp_beats.size();
      case (rmode)
        1: RREADY = ($urandom_range(0, 9) < 7);
        2: begin
          if (idx == 1 && RVALID && stall_left > 0) begin
            RREADY = 1'b0;
            stall_left--;
            chk("t3_stall_rdata", RDATA, VAL_B);
            chk("t3_stall_arready", ARREADY, 0);
          end else begin
            RREADY = 1'b1;
          end
        end
        3: begin
          if (idx == 1 && RVALID) begin
            RREADY = 1'b0;
            #2 rst = 1'b1;
            #1;
            chk("t6_rvalid", RVALID, 0);
            chk("t6_arready", ARREADY, 1);
            chk("t6_rlast", RLAST, 0);
            chk("t6_rdata", RDATA, 0);
            chk("t6_rid", RID, 0);
            chk("t6_mem_rd", mem_rd, 0);
            flush_model();
            repeat (2) @(posedge clk);
            #3 rst = 1'b0;
            return;
          end else begin
            RREADY = 1'b1;
          end
        end
        default: RREADY = 1'b1;
      endcase
      tick();
      n++;
    end
    chk("burst_complete", exp_beats.size(), 0);
    if (exp_beats.size() != 0) flush_model();
    RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          r;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom();
    mem[4] = VAL_A; mem[5] = VAL_B; mem[6] = VAL_C; mem[7] = VAL_D;
    mem[1022] = 32'h1022_1022; mem[1023] = 32'h1023_1023;

    #2 rst = 1'b1;
    #1;
    chk("rst_arready", ARREADY, 1);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rid", RID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 1: INCR, four beats A..D
    do_burst(4'd5, TB_BASE + 32'h10, 4'd3, 3'd2, 2'b01, 0);
    chk("t1_beats", got_data.size(), 4);
    chk("t1_d0", got_data[0], VAL_A);
    chk("t1_d1", got_data[1], VAL_B);
    chk("t1_d2", got_data[2], VAL_C);
    chk("t1_d3", got_data[3], VAL_D);
    chk("t1_last2", got_last[2], 0);
    chk("t1_last3", got_last[3], 1);
    chk("t1_resp0", got_resp[0], 0);
    chk("t1_rid", got_id[0], 5);
    chk("t1_latency", rv_cyc - hs_cyc, 2);

    // 2: WRAP 4 x 4 bytes starting at word 0xE
    do_burst(4'd2, TB_BASE + 32'h38, 4'd3, 3'd2, 2'b10, 0);
    chk("t2_words", got_words.size(), 4);
    chk("t2_w0", got_words[0], 14);
    chk("t2_w1", got_words[1], 15);
    chk("t2_w2", got_words[2], 12);
    chk("t2_w3", got_words[3], 13);
    chk("t2_last3", got_last[3], 1);

    // 3: stall on beat 2
    do_burst(4'd5, TB_BASE + 32'h10, 4'd3, 3'd2, 2'b01, 2);
    chk("t3_d1", got_data[1], VAL_B);
    chk("t3_memrd_count", got_words.size(), 4);

    // 4: reserved burst type
    do_burst(4'd9, TB_BASE + 32'h20, 4'd1, 3'd2, 2'b11, 0);
    chk("t4_beats", got_data.size(), 2);
    chk("t4_resp0", got_resp[0], 2);
    chk("t4_resp1", got_resp[1], 2);
    chk("t4_d0", got_data[0], 0);
    chk("t4_d1", got_data[1], 0);
    chk("t4_memrd_count", got_words.size(), 0);
    chk("t4_arready", ARREADY, 1);

    // 5: INCR running past the last memory word
    do_burst(4'd3, TB_BASE + 32'd4088, 4'd3, 3'd2, 2'b01, 0);
    chk("t5_resp0", got_resp[0], 0);
    chk("t5_resp1", got_resp[1], 0);
    chk("t5_resp2", got_resp[2], 2);
    chk("t5_resp3", got_resp[3], 2);
    chk("t5_d0", got_data[0], 32'h1022_1022);
    chk("t5_d1", got_data[1], 32'h1023_1023);
    chk("t5_d2", got_data[2], 0);
    chk("t5_d3", got_data[3], 0);

    // 6: asynchronous reset during beat 2, then a clean burst
    do_burst(4'd7, TB_BASE + 32'h10, 4'd3, 3'd2, 2'b01, 3);
    do_burst(4'd6, TB_BASE + 32'h10, 4'd3, 3'd2, 2'b01, 0);
    chk("t6_after_beats", got_data.size(), 4);
    chk("t6_after_d3", got_data[3], VAL_D);

    // Random bursts against the model
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      addr = TB_BASE + ($urandom_range(0, MEM_WORDS - 1) << 2);
      else if (r == 5) addr = TB_BASE + ($urandom_range(0, MEM_WORDS - 1) << 2) + $urandom_range(0, 3);
      else if (r == 6) addr = TB_BASE + ((MEM_WORDS - 4 + $urandom_range(0, 3)) << 2);
      else if (r == 7) addr = $urandom_range(0, TB_BASE - 1);
      else if (r == 8) addr = $urandom();
      else             addr = TB_BASE + (MEM_WORDS << 2) + ($urandom_range(0, 15) << 2);
      size  = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 7));
      r     = $urandom_range(0, 9);
      burst = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
      do_burst(4'($urandom()), addr, 4'($urandom()), size, burst, 1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
